// File: rtl/minterm_sweep_unit.sv
// minterm_sweep_unit
//
// Holds an N-input boolean function as a 2^N-bit minterm mask that is loaded
// serially at run time. The function is evaluated on a live input vector with
// one cycle of latency. On command it sweeps every input combination in
// truth-table order over a valid/ready stream, counts the minterms that are
// 1, and pulses done at the end.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   load_valid serial mask bit present this cycle
//   load_bit   mask bit value (first bit loaded ends up as mask[M-1])
//   start      request a sweep (ignored unless idle with a complete mask)
//   x_in       live input vector, MSB is the first variable
//   s_eval     registered f(x_in), 0 while the mask is incomplete
//   mask_valid all M mask bits have been loaded
//   busy       load, sweep or done cycle in progress
//   sw_valid   sweep entry present
//   sw_ready   consumer accepts the sweep entry
//   sw_idx     input combination of the current entry
//   sw_s       function value for sw_idx
//   ones       count of minterms equal to 1 (final when done pulses)
//   done       one-cycle pulse at the end of a sweep

module minterm_sweep_unit #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_valid,
    input  logic         load_bit,
    input  logic         start,
    input  logic [N-1:0] x_in,
    output logic         s_eval,
    output logic         mask_valid,
    output logic         busy,
    output logic         sw_valid,
    input  logic         sw_ready,
    output logic [N-1:0] sw_idx,
    output logic         sw_s,
    output logic [N:0]   ones,
    output logic         done
);

    localparam int M  = 2 ** N;
    // One extra bit so an all-ones mask counts to M without wrapping.
    localparam int CW = N + 1;
    localparam logic [N-1:0]  LAST_IDX = N'(M - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(M - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SWEEP,
        ST_DONE
    } state_t;

    state_t        r_state;
    logic [M-1:0]  r_mask;
    logic [CW-1:0] r_cnt;
    logic          r_mask_valid;
    logic          r_sw_valid;
    logic [N-1:0]  r_sw_idx;
    logic          r_sw_s;
    logic [CW-1:0] r_ones;
    logic          r_s_eval;

    state_t        w_state_next;
    logic [M-1:0]  w_mask_next;
    logic [CW-1:0] w_cnt_next;
    logic          w_mask_valid_next;
    logic          w_sw_valid_next;
    logic [N-1:0]  w_sw_idx_next;
    logic          w_sw_s_next;
    logic [CW-1:0] w_ones_next;
    logic          w_s_eval_next;
    logic          w_busy;
    logic          w_done;

    logic [N-1:0]  w_idx_inc;
    logic          w_xfer;

    assign w_idx_inc = r_sw_idx + N'(1);
    assign w_xfer    = r_sw_valid & sw_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_mask       <= '0;
            r_cnt        <= '0;
            r_mask_valid <= 1'b0;
            r_sw_valid   <= 1'b0;
            r_sw_idx     <= '0;
            r_sw_s       <= 1'b0;
            r_ones       <= '0;
            r_s_eval     <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_mask       <= w_mask_next;
            r_cnt        <= w_cnt_next;
            r_mask_valid <= w_mask_valid_next;
            r_sw_valid   <= w_sw_valid_next;
            r_sw_idx     <= w_sw_idx_next;
            r_sw_s       <= w_sw_s_next;
            r_ones       <= w_ones_next;
            r_s_eval     <= w_s_eval_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_mask_next       = r_mask;
        w_cnt_next        = r_cnt;
        w_mask_valid_next = r_mask_valid;
        w_sw_valid_next   = r_sw_valid;
        w_sw_idx_next     = r_sw_idx;
        w_sw_s_next       = r_sw_s;
        w_ones_next       = r_ones;
        w_busy            = 1'b1;
        w_done            = 1'b0;

        // Evaluation runs in every state; an incomplete mask reads as 0.
        w_s_eval_next = r_mask_valid & r_mask[x_in];

        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                // A load beats a simultaneous start; the start is dropped.
                if (load_valid) begin
                    w_mask_valid_next = 1'b0;
                    w_mask_next       = {r_mask[M-2:0], load_bit};
                    w_cnt_next        = CW'(1);
                    w_state_next      = ST_LOAD;
                end else if (start && r_mask_valid) begin
                    // First entry is presented straight from the accept edge.
                    w_sw_valid_next = 1'b1;
                    w_sw_idx_next   = '0;
                    w_sw_s_next     = r_mask[0];
                    w_ones_next     = '0;
                    w_state_next    = ST_SWEEP;
                end
            end

            ST_LOAD: begin
                if (load_valid) begin
                    w_mask_next = {r_mask[M-2:0], load_bit};
                    w_cnt_next  = r_cnt + CW'(1);
                    if (r_cnt == LAST_CNT) begin
                        w_mask_valid_next = 1'b1;
                        w_state_next      = ST_IDLE;
                    end
                end
            end

            ST_SWEEP: begin
                if (w_xfer) begin
                    w_ones_next = r_ones + {{N{1'b0}}, r_sw_s};
                    if (r_sw_idx == LAST_IDX) begin
                        w_sw_valid_next = 1'b0;
                        w_state_next    = ST_DONE;
                    end else begin
                        w_sw_idx_next = w_idx_inc;
                        w_sw_s_next   = r_mask[w_idx_inc];
                    end
                end
            end

            ST_DONE: begin
                w_done       = 1'b1;
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign s_eval     = r_s_eval;
    assign mask_valid = r_mask_valid;
    assign busy       = w_busy;
    assign sw_valid   = r_sw_valid;
    assign sw_idx     = r_sw_idx;
    assign sw_s       = r_sw_s;
    assign ones       = r_ones;
    assign done       = w_done;

endmodule

// File: tb/tb_minterm_sweep_unit.sv
// Bench for minterm_sweep_unit: one instance with N=4 and one with N=3.
// Sweep entries and final counts are pushed into scoreboard queues by the
// stimulus; a negedge monitor pops and compares them as the DUTs present
// transfers and done pulses. Static behaviour (reset, s_eval, ignored
// starts) is compared directly against hand-computed constants.

module tb_minterm_sweep_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    // N=4 instance
    logic       load_valid4 = 0, load_bit4 = 0, start4 = 0, rdy4 = 0;
    logic [3:0] x4 = '0;
    logic       s_eval4, mask_valid4, busy4, sw_valid4, sw_s4, done4;
    logic [3:0] sw_idx4;
    logic [4:0] ones4;

    // N=3 instance
    logic       load_valid3 = 0, load_bit3 = 0, start3 = 0, rdy3 = 0;
    logic [2:0] x3 = '0;
    logic       s_eval3, mask_valid3, busy3, sw_valid3, sw_s3, done3;
    logic [2:0] sw_idx3;
    logic [3:0] ones3;

    minterm_sweep_unit #(.N(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid4), .load_bit(load_bit4),
        .start(start4), .x_in(x4), .s_eval(s_eval4), .mask_valid(mask_valid4),
        .busy(busy4), .sw_valid(sw_valid4), .sw_ready(rdy4), .sw_idx(sw_idx4),
        .sw_s(sw_s4), .ones(ones4), .done(done4)
    );

    minterm_sweep_unit #(.N(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid3), .load_bit(load_bit3),
        .start(start3), .x_in(x3), .s_eval(s_eval3), .mask_valid(mask_valid3),
        .busy(busy3), .sw_valid(sw_valid3), .sw_ready(rdy3), .sw_idx(sw_idx3),
        .sw_s(sw_s3), .ones(ones3), .done(done3)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard: entry = idx*2 + s; ones_q holds the expected final count.
    int ent_q[$];
    int ones_q[$];

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    logic mv, mr, ms, md;
    int   mi, mo, mlast, ment;
    logic prev_stall[2];
    logic prev_last[2];
    int   prev_idx[2];
    logic prev_s[2];

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                prev_stall[d] <= 1'b0;
                prev_last[d]  <= 1'b0;
                prev_idx[d]   <= 0;
                prev_s[d]     <= 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                mv    = (d == 1) ? sw_valid3 : sw_valid4;
                mr    = (d == 1) ? rdy3      : rdy4;
                ms    = (d == 1) ? sw_s3     : sw_s4;
                md    = (d == 1) ? done3     : done4;
                mi    = (d == 1) ? int'(sw_idx3) : int'(sw_idx4);
                mo    = (d == 1) ? int'(ones3)   : int'(ones4);
                mlast = (d == 1) ? 7 : 15;

                // done must pulse exactly the cycle after the last transfer.
                if (md || prev_last[d]) check("done_after_last", int'(md), int'(prev_last[d]));
                if (prev_last[d]) check("valid_dropped", int'(mv), 0);
                if (md) begin
                    if (ones_q.size() == 0) check("done_unexpected", 1, 0);
                    else begin
                        ment = ones_q.pop_front();
                        $display("dut%0d done ones=%0d", d, mo);
                        check("ones_final", mo, ment);
                    end
                end
                if (prev_stall[d] && mv) begin
                    check("stall_idx_stable", mi, prev_idx[d]);
                    check("stall_s_stable", int'(ms), int'(prev_s[d]));
                end
                if (mv && mr) begin
                    if (ent_q.size() == 0) check("entry_unexpected", 1, 0);
                    else begin
                        ment = ent_q.pop_front();
                        $display("dut%0d entry idx=%0d s=%0d", d, mi, ms);
                        check("sw_idx", mi, ment / 2);
                        check("sw_s", int'(ms), ment % 2);
                    end
                end
                prev_stall[d] <= mv & ~mr;
                prev_last[d]  <= mv & mr & (mi == mlast);
                prev_idx[d]   <= mi;
                prev_s[d]     <= ms;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Shift bits first..last of val, MSB (bit m-1) first.
    task automatic load_bits(input bit d3, input logic [15:0] val, input int first, input int last);
        int m;
        m = d3 ? 8 : 16;
        for (int k = first; k <= last; k++) begin
            if (d3) begin load_valid3 = 1'b1; load_bit3 = val[m-1-k]; end
            else    begin load_valid4 = 1'b1; load_bit4 = val[m-1-k]; end
            tick();
        end
        load_valid3 = 1'b0;
        load_valid4 = 1'b0;
    endtask

    task automatic push_sweep(input bit d3, input logic [15:0] val, input int exp_ones);
        int m;
        m = d3 ? 8 : 16;
        for (int i = 0; i < m; i++) ent_q.push_back(i * 2 + int'(val[i]));
        ones_q.push_back(exp_ones);
    endtask

    task automatic sweep(input bit d3, input logic [15:0] val, input int exp_ones, input bit stall);
        bit seen;
        seen = 1'b0;
        push_sweep(d3, val, exp_ones);
        if (d3) begin start3 = 1'b1; rdy3 = 1'b1; end
        else    begin start4 = 1'b1; rdy4 = 1'b1; end
        tick();
        start3 = 1'b0;
        start4 = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            if (d3) rdy3 = stall ? (c % 3 == 0) : 1'b1;
            else    rdy4 = stall ? (c % 3 == 0) : 1'b1;
            tick();
            seen = d3 ? done3 : done4;
        end
        if (!seen) check("sweep_timeout", 0, 1);
        rdy3 = 1'b0;
        rdy4 = 1'b0;
        tick();
    endtask

    task automatic check_outputs_zero();
        check("rst_s_eval", int'(s_eval4), 0);
        check("rst_mask_valid", int'(mask_valid4), 0);
        check("rst_busy", int'(busy4), 0);
        check("rst_sw_valid", int'(sw_valid4), 0);
        check("rst_sw_idx", int'(sw_idx4), 0);
        check("rst_sw_s", int'(sw_s4), 0);
        check("rst_ones", int'(ones4), 0);
        check("rst_done", int'(done4), 0);
        check("rst_dut3_all", int'({s_eval3, mask_valid3, busy3, sw_valid3, sw_idx3, sw_s3, ones3, done3}), 0);
    endtask

    localparam logic [15:0] MASK_A = 16'h41C5;  // minterms 0,2,6,7,8,14

    int sev_x[5] = '{7, 5, 14, 8, 15};
    int sev_e[5] = '{1, 0, 1, 1, 0};
    bit hit;

    initial begin
        #2 rst_n = 1'b0;
        #2 check_outputs_zero();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Empty mask: s_eval stays 0 for every input.
        for (int x = 0; x < 16; x++) begin
            x4 = 4'(x);
            tick();
            check("s_eval_no_mask", int'(s_eval4), 0);
        end

        // Start with no mask is ignored.
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("start_no_mask_valid", int'(sw_valid4), 0);
        tick();
        check("start_no_mask_busy", int'(busy4), 0);

        // Partial load (10 bits), then a start during the gap.
        load_bits(1'b0, MASK_A, 0, 9);
        check("partial_busy", int'(busy4), 1);
        check("partial_mask_valid", int'(mask_valid4), 0);
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        check("start_in_load_valid", int'(sw_valid4), 0);
        check("start_in_load_busy", int'(busy4), 1);
        load_bits(1'b0, MASK_A, 10, 15);
        check("load_done_mask_valid", int'(mask_valid4), 1);
        check("load_done_busy", int'(busy4), 0);

        // Live evaluation, one cycle latency.
        for (int t = 0; t < 5; t++) begin
            x4 = 4'(sev_x[t]);
            tick();
            $display("s_eval x=%0d -> %0d", sev_x[t], s_eval4);
            check("s_eval", int'(s_eval4), sev_e[t]);
        end

        // Sweeps with ready held high and with a 1,0,0 stall pattern.
        sweep(1'b0, MASK_A, 6, 1'b0);
        tick();
        check("ones_hold", int'(ones4), 6);
        check("idle_after_done", int'(busy4), 0);
        sweep(1'b0, MASK_A, 6, 1'b1);

        // Load and start in the same idle cycle: load wins.
        load_valid4 = 1'b1;
        load_bit4   = MASK_A[15];
        start4      = 1'b1;
        tick();
        load_valid4 = 1'b0;
        start4      = 1'b0;
        check("collide_mask_valid", int'(mask_valid4), 0);
        check("collide_busy", int'(busy4), 1);
        check("collide_sw_valid", int'(sw_valid4), 0);
        load_bits(1'b0, MASK_A, 1, 15);
        check("reload_mask_valid", int'(mask_valid4), 1);

        // Reset in the middle of a sweep, at idx 5.
        push_sweep(1'b0, MASK_A, 6);
        start4 = 1'b1;
        rdy4   = 1'b1;
        tick();
        start4 = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            if (sw_valid4 && sw_idx4 == 4'd5) hit = 1'b1;
            else tick();
        end
        check("reach_idx5", int'(hit), 1);
        rst_n = 1'b0;
        #2 check_outputs_zero();
        ent_q.delete();
        ones_q.delete();
        rdy4 = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_mask_valid", int'(mask_valid4), 0);
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("post_rst_start_ignored", int'(sw_valid4), 0);
        tick();
        check("post_rst_busy", int'(busy4), 0);

        // N=3: all-ones mask counts to 8, then all-zeros to 0.
        load_bits(1'b1, 16'h00FF, 0, 7);
        check("n3_mask_valid", int'(mask_valid3), 1);
        sweep(1'b1, 16'h00FF, 8, 1'b0);
        load_bits(1'b1, 16'h0000, 0, 7);
        sweep(1'b1, 16'h0000, 0, 1'b1);

        tick();
        check("entries_left", ent_q.size(), 0);
        check("dones_left", ones_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/minterm_sweep_unit.md
Name: minterm_sweep_unit

Overview:
- Parametrised, sequential successor to the fixed 4-input sum-of-products blocks.
- Holds an N-input boolean function as a 2^N-bit minterm mask, loaded serially at run time.
- Evaluates the function on a live input vector with 1-cycle latency.
- On command, sweeps every input combination in truth-table order over a valid/ready stream, counts the asserted minterms, and pulses done. This replaces hand-written exhaustive testbench sweeps.

Parameters:
- N, 4, number of function inputs. Legal range 2..6.
- M, 2**N, mask width / number of minterms. Derived only; never overridden.
- CW, N+1, width of the minterm counter (holds 0..M).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  serial mask bit present this cycle.
- load_bit  input  1  mask bit value.
- start  input  1  request a sweep; single-cycle pulse expected.
- x_in  input  N  live input vector; MSB is the first variable (x), LSB the last (z).
- s_eval  output  1  registered f(x_in).
- mask_valid  output  1  all M mask bits have been loaded.
- busy  output  1  load or sweep in progress.
- sw_valid  output  1  a sweep entry is present.
- sw_ready  input  1  consumer accepts the sweep entry.
- sw_idx  output  N  input combination of the current entry.
- sw_s  output  1  function value for sw_idx.
- ones  output  CW  number of minterms equal to 1; final value is valid when done pulses.
- done  output  1  one-cycle pulse at the end of a sweep.

Behaviour:
- Mask bit i corresponds to minterm i, where i = {x,...,z} read as unsigned binary.
- Reset (async, rst_n=0):
  - mask=0, bit count=0, state=IDLE.
  - All outputs 0: s_eval, mask_valid, busy, sw_valid, sw_idx, sw_s, ones, done.
  - A reset asserted mid-load or mid-sweep aborts it immediately; the bench must see all outputs 0 within the reset assertion.
- States: IDLE, LOAD, SWEEP, DONE.
- IDLE:
  - load_valid=1: clear mask_valid, shift the bit in, count=1, go to LOAD.
  - start=1 with mask_valid=1 and load_valid=0: idx=0, ones=0, go to SWEEP.
  - start with mask_valid=0 is ignored.
  - load_valid and start together: load wins; start is dropped.
- LOAD:
  - Each load_valid cycle: mask <= {mask[M-2:0], load_bit}, count++. The first bit loaded ends as mask[M-1]; the last loaded is mask[0].
  - Gaps (load_valid=0) are allowed; state and count are held.
  - When the M-th bit is shifted in: mask_valid=1 from the next cycle, go to IDLE.
  - start is ignored in LOAD.
- SWEEP:
  - sw_valid=1, sw_idx=idx, sw_s=mask[idx], all registered. The first entry appears one cycle after start is accepted.
  - Transfer occurs on sw_valid & sw_ready. On transfer: ones += sw_s, idx++.
  - Without sw_ready, sw_idx and sw_s stay stable.
  - Transfer of idx=M-1: sw_valid drops next cycle, go to DONE.
  - load_valid and start are ignored in SWEEP.
- DONE: done=1 for exactly one cycle, ones holds the final count, then go to IDLE.
- ones holds its value until the next accepted start.
- busy=1 in LOAD, SWEEP and DONE.
- s_eval:
  - Every cycle s_eval <= mask_valid ? mask[x_in] : 0, giving 1-cycle latency.
  - It keeps evaluating during a sweep.
  - During LOAD it is 0, because mask_valid is 0.
- Width rule: ones reaches M (all-ones mask) without overflow. idx never wraps inside a sweep.

Test Plan:
- N=4: reset, load 16 bits forming mask 16'h41C5 (minterms 0,2,6,7,8,14), sw_ready held 1, pulse start -> 16 consecutive entries idx 0..15 with sw_s=1 exactly at 0,2,6,7,8,14; done pulses the cycle after the last transfer; ones=6.
- Same sweep with sw_ready toggled 1,0,0,1,... -> no index skipped or duplicated; sw_idx and sw_s stable while stalled; ones=6.
- After the load above, drive x_in=4'b0111 then 4'b0101 -> s_eval=1 then 0, each one cycle later. Before any load, s_eval=0 for all x_in.
- Start before the mask is complete (10 bits loaded) -> ignored, sw_valid stays 0. load_valid and start in the same IDLE cycle -> load taken, mask_valid=0.
- Assert rst_n=0 at idx=5 of a sweep -> all outputs 0 asynchronously. After release: mask_valid=0, and start is ignored until a reload.
- N=3 with mask all ones (8'hFF) -> 8 entries all sw_s=1, ones=8 (CW=4, no overflow); reload 8'h00 -> ones=0.
